segmentation_ctrl: RTL and testbench
====================================

Name: segmentation_ctrl

Overview:
Sequencer for the 8-lane segmentation block RAM in the compression path. In LOAD mode it streams lane vectors from a producer into consecutive RAM addresses. In READ mode it scans consecutive addresses and emits 8x8 blocks (8 addresses x DIM lanes) to the downstream compression stage over a valid/ready stream. It hides the RAM's 1-cycle registered read latency behind a 2-entry buffer, so back-pressure never loses data.

Parameters:
DIM, 8, lanes per RAM word (one pixel per lane)
WIDTH, 8, bits per pixel
DEPTH, 8192, RAM words per lane
ADDR, $clog2(DEPTH), address width
BLK_ROWS, 8, addresses per block

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle command strobe, sampled only in IDLE
mode  in  1  0 = READ scan, 1 = LOAD; sampled with start
base_addr  in  ADDR  first RAM address of the job
num_blocks  in  ADDR-2  block count; job length = num_blocks*BLK_ROWS addresses
busy  out  1  high from accepted start until DONE inclusive
done  out  1  one-cycle pulse at job completion
in_valid  in  1  LOAD data valid
in_ready  out  1  LOAD data accepted this cycle
in_data  in  WIDTH x DIM  LOAD lane vector
out_valid  out  1  READ data valid
out_ready  in  1  downstream accept
out_data  out  WIDTH x DIM  READ lane vector
out_row_last  out  1  marks the 8th address of a block
out_job_last  out  1  marks the final vector of the job
mem_we  out  1  RAM write enable
mem_addr  out  ADDR  RAM address
mem_di  out  WIDTH x DIM  RAM write data
mem_dout  in  WIDTH x DIM  RAM registered read data, valid 1 cycle after address with mem_we=0

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, in_ready, out_valid, mem_we, out_row_last, out_job_last = 0. mem_addr=0, mem_di=0, out_data=0. Buffer emptied, in-flight flag cleared, counters cleared.
- FSM states: IDLE, LOAD, READ, DONE.
  - IDLE->LOAD/READ on start; latch base_addr, num_blocks, mode.
  - start with num_blocks==0 -> DONE directly, no RAM access.
  - start while not IDLE is ignored.
- Address counter: addr = base_addr + idx, wrapping modulo DEPTH (DEPTH is a power of 2). idx counts 0..N-1, N = num_blocks*BLK_ROWS.
- LOAD:
  - in_ready=1 while idx<N.
  - mem_we = in_valid & in_ready (combinational); mem_addr = current addr; mem_di = in_data.
  - idx increments per accepted beat.
  - Last accepted beat -> DONE next cycle.
- READ:
  - mem_we held 0.
  - Issue rule: issue address idx when idx<N and (count + inflight - pop) < 2. count = buffer occupancy (0..2); inflight = read issued last cycle; pop = out_valid & out_ready.
  - Issue sets inflight for the next cycle. mem_addr is registered and holds its value when not issuing.
  - mem_dout is captured into the buffer the cycle after issue, tagged with row_last = (idx mod BLK_ROWS == BLK_ROWS-1) and job_last = (idx==N-1).
  - out_valid = count>0; head-of-buffer drives out_data and the tags.
  - Sustained throughput is 1 vector/cycle with out_ready held high. First out_valid appears 2 cycles after start.
  - Simultaneous push and pop are legal; occupancy is unchanged.
  - out_data/tags stay stable while out_valid & !out_ready.
  - Pop of the job_last entry -> DONE next cycle.
- DONE: done=1, busy=1 for exactly one cycle, then IDLE.
- Width: idx and N are ADDR+1 bits wide. N = DEPTH is legal (full-RAM scan); N > DEPTH is not, and behaviour for it is undefined.

Decomposition:
- Package seg_pkg: pixel_t (logic[WIDTH-1:0]), lane vector typedef, seg_state_e enum {IDLE, LOAD, READ, DONE}, BLK_ROWS constant, mode encoding constants.
- Sub-module seg_skid_fifo: 2-entry FIFO of {lane vector, row_last, job_last}, with push/pop/count.

Test Plan:
- LOAD base=0, num_blocks=1, in_data lane k = 8*row+k, in_valid always 1 -> mem_we high exactly 8 cycles, addresses 0..7; done one cycle after the 8th beat.
- READ base=0, num_blocks=2, out_ready=1 -> 16 consecutive out_valid beats starting 2 cycles after start; out_row_last on beats 8 and 16; out_job_last on beat 16; data matches the preloaded RAM.
- READ with out_ready toggled 1,0,0,1 repeatedly -> no vector lost or duplicated, data stable during stalls, occupancy never exceeds 2.
- READ base=8188, num_blocks=1 -> addresses 8188..8191, 0..3 (wrap); out_row_last on the 8th beat.
- start with num_blocks=0 -> done pulses 1 cycle later, mem_we=0, no out_valid.
- rst asserted mid-READ after 5 beats, with buffer full -> outputs zero immediately; a new start then completes a full job correctly.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types and constants for the segmentation RAM sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int DIM      = 8;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 8192;
    localparam int ADDR     = $clog2(DEPTH);
    localparam int BLK_ROWS = 8;
    localparam int ROW_BITS = $clog2(BLK_ROWS);
    localparam int CNT_W    = ADDR + 1;

    localparam logic MODE_READ = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

    typedef logic [WIDTH-1:0] pixel_t;
    typedef pixel_t [DIM-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } seg_state_e;

    typedef struct packed {
        lane_vec_t data;
        logic      row_last;
        logic      job_last;
    } seg_entry_t;

    // Job length in addresses; one bit wider than ADDR so a full-RAM scan fits.
    function automatic logic [CNT_W-1:0] job_len(input logic [ADDR-3:0] nb);
        return CNT_W'(nb) * CNT_W'(BLK_ROWS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : seg_skid_fifo
// Description : Two-entry buffer absorbing RAM read data under back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_skid_fifo
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  seg_entry_t i_entry,
    output seg_entry_t o_head,
    output logic [1:0] o_count
);

    seg_entry_t r_mem [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/segmentation_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : segmentation_ctrl
// Description : LOAD/READ sequencer for the 8-lane segmentation block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module segmentation_ctrl
    import seg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR-1:0]   base_addr,
    input  logic [ADDR-3:0]   num_blocks,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  lane_vec_t         in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output lane_vec_t         out_data,
    output logic              out_row_last,
    output logic              out_job_last,
    output logic              mem_we,
    output logic [ADDR-1:0]   mem_addr,
    output lane_vec_t         mem_di,
    input  lane_vec_t         mem_dout
);

    seg_state_e       r_state;
    logic [ADDR-1:0]  r_base;
    logic [ADDR-1:0]  r_mem_addr;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_idx;
    logic             r_inflight;
    logic             r_tag_row;
    logic             r_tag_job;

    logic [ADDR-1:0]  w_addr;
    logic             w_more;
    logic             w_last_idx;
    logic             w_accept;
    logic             w_pop;
    logic             w_issue;
    logic [2:0]       w_level;
    logic [1:0]       w_count;
    seg_entry_t       w_head;
    seg_entry_t       w_push_entry;

    assign w_addr     = r_base + r_idx[ADDR-1:0];
    assign w_more     = r_idx < r_len;
    assign w_last_idx = r_idx == (r_len - CNT_W'(1));
    assign w_accept   = (r_state == LOAD) && w_more && in_valid;
    assign w_pop      = out_valid && out_ready;

    // Occupancy the buffer will hold once the outstanding read lands; a new
    // read is only launched if that still leaves room for it.
    assign w_level = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == READ) && w_more && (w_level < 3'd2);

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign in_ready = (r_state == LOAD) && w_more;
    assign mem_we   = w_accept;
    assign mem_di   = (r_state == LOAD) ? in_data : '0;
    assign mem_addr = ((r_state == LOAD) || w_issue) ? w_addr : r_mem_addr;

    assign out_valid    = (w_count != 2'd0);
    assign out_data     = out_valid ? w_head.data : '0;
    assign out_row_last = out_valid && w_head.row_last;
    assign out_job_last = out_valid && w_head.job_last;

    assign w_push_entry = '{data: mem_dout, row_last: r_tag_row, job_last: r_tag_job};

    seg_skid_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_entry (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_mem_addr <= '0;
            r_inflight <= 1'b0;
            r_tag_row  <= 1'b0;
            r_tag_job  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base <= base_addr;
                        r_len  <= job_len(num_blocks);
                        r_idx  <= '0;
                        if (num_blocks == '0) begin
                            r_state <= DONE;
                        end else if (mode == MODE_LOAD) begin
                            r_state <= LOAD;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_idx <= r_idx + CNT_W'(1);
                        if (w_last_idx) begin
                            r_state <= DONE;
                        end
                    end
                end
                READ: begin
                    if (w_issue) begin
                        r_idx      <= r_idx + CNT_W'(1);
                        r_mem_addr <= w_addr;
                        r_tag_row  <= (r_idx[ROW_BITS-1:0] == ROW_BITS'(BLK_ROWS - 1));
                        r_tag_job  <= w_last_idx;
                    end
                    if (w_pop && w_head.job_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_segmentation_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_segmentation_ctrl
// Description : Table-driven, scoreboarded bench for segmentation_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segmentation_ctrl;
    import seg_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            mode;
    logic [ADDR-1:0] base_addr;
    logic [ADDR-3:0] num_blocks;
    logic            busy;
    logic            done;
    logic            in_valid;
    logic            in_ready;
    lane_vec_t       in_data;
    logic            out_valid;
    logic            out_ready;
    lane_vec_t       out_data;
    logic            out_row_last;
    logic            out_job_last;
    logic            mem_we;
    logic [ADDR-1:0] mem_addr;
    lane_vec_t       mem_di;
    lane_vec_t       mem_dout;

    always #5 clk = ~clk;

    segmentation_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .base_addr    (base_addr),
        .num_blocks   (num_blocks),
        .busy         (busy),
        .done         (done),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row_last (out_row_last),
        .out_job_last (out_job_last),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_di       (mem_di),
        .mem_dout     (mem_dout)
    );

    // Block RAM with a one-cycle registered read port.
    lane_vec_t ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_di;
        mem_dout <= ram[mem_addr];
    end

    typedef struct {
        logic            m;
        logic [ADDR-1:0] base;
        logic [ADDR-3:0] nblk;
        int              seed;
        logic [3:0]      pat;
        bit              poke;
        int              exp_writes;
        int              exp_beats;
        int              exp_lat;
    } job_t;

    typedef struct {
        lane_vec_t data;
        logic      row;
        logic      job;
    } beat_t;

    typedef struct {
        logic [ADDR-1:0] addr;
        lane_vec_t       data;
    } wr_t;

    beat_t     exp_q[$];
    wr_t       exp_w[$];
    lane_vec_t model [DEPTH];
    job_t      jobs [9];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int start_cyc, first_valid_cyc, last_acc_cyc, last_pop_cyc, done_cyc;
    int ndone, nwrites, nbeats;
    bit acc     = 1'b0;
    bit stalled = 1'b0;
    lane_vec_t prev_data;
    logic prev_row, prev_job;

    task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic lane_vec_t gen(input int seed, input int k);
        lane_vec_t v;
        for (int i = 0; i < DIM; i++) v[i] = pixel_t'(seed * 37 + 8 * k + i);
        return v;
    endfunction

    // One clock: sample everything at the falling edge, return just after the rising edge.
    task automatic cycle();
        beat_t b;
        wr_t   w;
        @(negedge clk);
        cyc++;
        if (start && start_cyc < 0) start_cyc = cyc;
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stalled)
            chk_vec("stall_hold", 128'({out_valid, out_row_last, out_job_last, out_data}),
                    128'({1'b1, prev_row, prev_job, prev_data}));
        stalled   = out_valid && !out_ready;
        prev_data = out_data;
        prev_row  = out_row_last;
        prev_job  = out_job_last;
        if (out_valid && out_ready) begin
            nbeats++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_beat: got %h want no beat (cycle %0d)", out_data, cyc);
            end else begin
                b = exp_q.pop_front();
                chk_vec("beat", 128'({out_data, out_row_last, out_job_last}),
                        128'({b.data, b.row, b.job}));
            end
            if (out_job_last) last_pop_cyc = cyc;
        end
        if (mem_we) begin
            nwrites++;
            if (exp_w.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_write: got addr %0d want no write (cycle %0d)", mem_addr, cyc);
            end else begin
                w = exp_w.pop_front();
                chk_vec("write", 128'({mem_addr, mem_di}), 128'({w.addr, w.data}));
            end
        end
        acc = in_valid && in_ready;
        if (acc) last_acc_cyc = cyc;
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_beat(input job_t j, input int k);
        wr_t w;
        w.addr = j.base + ADDR'(k);
        w.data = gen(j.seed, k);
        in_data = w.data;
        exp_w.push_back(w);
        model[w.addr] = w.data;
    endtask

    task automatic push_reads(input logic [ADDR-1:0] base, input int n);
        beat_t b;
        logic [ADDR-1:0] a;
        for (int k = 0; k < n; k++) begin
            a = base + ADDR'(k);
            b.data = model[a];
            b.row  = ((k % BLK_ROWS) == BLK_ROWS - 1);
            b.job  = (k == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic clear_stats();
        start_cyc = -1; first_valid_cyc = -1; last_acc_cyc = -1;
        last_pop_cyc = -1; done_cyc = -1;
        ndone = 0; nwrites = 0; nbeats = 0;
    endtask

    task automatic run_job(input job_t j);
        int n, k, budget, budget0;
        n = int'(j.nblk) * BLK_ROWS;
        clear_stats();
        if (j.m == MODE_READ) push_reads(j.base, n);
        start = 1'b1; mode = j.m; base_addr = j.base; num_blocks = j.nblk;
        out_ready = j.pat[0];
        cycle();
        // Scramble the command inputs to prove they were latched.
        start = 1'b0; mode = ~j.m; base_addr = '1; num_blocks = '1;
        chk_vec("busy_after_start", 128'(busy), 128'(1));
        k = 0;
        if (j.m == MODE_LOAD) begin
            in_valid = 1'b1;
            if (n > 0) load_beat(j, 0);
        end
        budget0 = 40 + 4 * n;
        budget  = budget0;
        while (ndone == 0 && budget > 0) begin
            out_ready = j.pat[cyc % 4];
            start = (j.poke && budget == budget0 - 6);
            cycle();
            start = 1'b0;
            budget--;
            if (j.m == MODE_LOAD && acc) begin
                k++;
                if (k < n) load_beat(j, k);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (ndone == 0) begin
            checks++;
            errors++;
            $display("FAIL job_timeout: got no done want done within %0d cycles", budget0);
        end
        cycle();
        chk_vec("idle_after_done", 128'({busy, done}), 128'(0));
        chk_int("done_pulses", ndone, 1);
        chk_int("writes", nwrites, j.exp_writes);
        chk_int("beats", nbeats, j.exp_beats);
        if (n == 0)
            chk_int("done_time", done_cyc - start_cyc, 1);
        else if (j.m == MODE_LOAD)
            chk_int("done_time", done_cyc - last_acc_cyc, 1);
        else
            chk_int("done_time", done_cyc - last_pop_cyc, 1);
        if (j.exp_lat >= 0)
            chk_int("first_valid_lat", first_valid_cyc - start_cyc - 1, j.exp_lat);
        else
            chk_int("no_out_valid", first_valid_cyc, -1);
        exp_q.delete();
        exp_w.delete();
    endtask

    initial begin
        job_t jr;
        //          mode       base       nblk   seed pat   poke wr  beats lat
        jobs[0] = '{MODE_LOAD, 13'd0,    11'd1, 0,   4'hF, 1'b0, 8,  0,   -1};
        jobs[1] = '{MODE_LOAD, 13'd8,    11'd1, 1,   4'hF, 1'b0, 8,  0,   -1};
        jobs[2] = '{MODE_READ, 13'd0,    11'd2, 0,   4'hF, 1'b0, 0,  16,  2};
        jobs[3] = '{MODE_READ, 13'd0,    11'd2, 0,   4'h9, 1'b1, 0,  16,  2};
        jobs[4] = '{MODE_LOAD, 13'd8188, 11'd1, 2,   4'hF, 1'b0, 8,  0,   -1};
        jobs[5] = '{MODE_READ, 13'd8188, 11'd1, 0,   4'hF, 1'b0, 0,  8,   2};
        jobs[6] = '{MODE_READ, 13'd100,  11'd0, 0,   4'hF, 1'b0, 0,  0,   -1};
        jobs[7] = '{MODE_LOAD, 13'd5,    11'd0, 3,   4'hF, 1'b0, 0,  0,   -1};
        jobs[8] = '{MODE_READ, 13'd8188, 11'd1, 0,   4'h6, 1'b0, 0,  8,   2};

        rst = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0; num_blocks = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_vec("reset_ctrl", 128'({busy, done, in_ready, out_valid, mem_we,
                                    out_row_last, out_job_last, mem_addr}), 128'(0));
        chk_vec("reset_data", 128'({mem_di, out_data}), 128'(0));
        #20 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) run_job(jobs[i]);

        // Reset in the middle of a READ with both buffer entries occupied.
        clear_stats();
        push_reads(13'd0, 16);
        start = 1'b1; mode = MODE_READ; base_addr = '0; num_blocks = 11'd2; out_ready = 1'b1;
        cycle();
        start = 1'b0;
        for (int t = 0; t < 30 && nbeats < 5; t++) cycle();
        chk_int("rst_pre_beats", nbeats, 5);
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) cycle();
        chk_vec("rst_pre_valid", 128'({busy, out_valid}), 128'(2'b11));
        #2 rst = 1'b1;
        #1;
        chk_vec("rst_async_ctrl", 128'({busy, done, in_ready, out_valid, mem_we,
                                        out_row_last, out_job_last, mem_addr}), 128'(0));
        chk_vec("rst_async_data", 128'({mem_di, out_data}), 128'(0));
        exp_q.delete();
        stalled = 1'b0;
        @(negedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk_vec("rst_idle", 128'({busy, out_valid}), 128'(0));
        jr = '{MODE_READ, 13'd0, 11'd2, 0, 4'hF, 1'b0, 0, 16, 2};
        run_job(jr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
